fir_seq_ctrl: RTL and testbench
===============================

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter NGROUPS, default 3: number of coefficient groups time-multiplexed per sample (range 2..16).
REQ-002 SHALL have parameter MULT_LAT, default 2: multiplier pipeline latency in cycles (range 1..8).
REQ-003 SHALL have parameter ACC_STAGES, default 2: partial-product accumulation cycles per sample (range 1..NGROUPS).
REQ-004 SHALL have parameter CNT_W, default 16: width of sample_cnt.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 push_coef  input  1  coefficient load request; aborts sample in flight.
REQ-008 fifo_empty  input  1  input sample FIFO empty.
REQ-009 fifo_pull  output  1  pop one sample from FIFO this cycle.
REQ-010 grp_sel  output  GSEL_W  multiplier operand mux select; GSEL_W = max(1, clog2(NGROUPS)).
REQ-011 pp_acc_valid  output  1  partial-product accumulator enable.
REQ-012 final_round_en  output  1  final accumulate/round enable, one cycle per sample.
REQ-013 busy  output  1  high when multiplier FSM is not IDLE or any token is in the delay line.
REQ-014 sample_cnt  output  CNT_W  count of completed samples, wraps modulo 2^CNT_W.

Function
REQ-015 Multiplier FSM SHALL have states IDLE, FETCH, MULT; registered state, combinational next-state and fifo_pull.
REQ-016 IDLE: fifo_empty=0 -> fifo_pull=1, next FETCH; else stay, fifo_pull=0.
REQ-017 FETCH SHALL last exactly one cycle, then MULT with grp_sel=0.
REQ-018 MULT: grp_sel increments by 1 per cycle, 0..NGROUPS-1; grp_sel is 0 in all other states.
REQ-019 MULT with grp_sel=NGROUPS-1: fifo_empty=0 -> fifo_pull=1, next FETCH; else next IDLE; a sample token is issued this cycle.
REQ-020 push_coef=1 in FETCH or MULT SHALL force next state IDLE, suppress fifo_pull and token issue that cycle, and clear all tokens in the delay line; push_coef in IDLE blocks fifo_pull that cycle.
REQ-021 Token issued at cycle t SHALL produce pp_acc_valid=1 in cycles t+MULT_LAT .. t+MULT_LAT+ACC_STAGES-1 and final_round_en=1 in cycle t+MULT_LAT+ACC_STAGES.
REQ-022 Minimum sample period is NGROUPS+1 cycles; with REQ-003 accumulation windows of consecutive tokens SHALL never overlap; multiple tokens in flight SHALL be supported.
REQ-023 sample_cnt SHALL increment by 1 in the cycle after each final_round_en, wrapping from 2^CNT_W-1 to 0.
REQ-024 fifo_pull SHALL never assert when fifo_empty=1.
REQ-025 Out-of-range parameters SHALL cause an elaboration-time error.

Reset
REQ-026 reset=1 SHALL asynchronously force state IDLE, grp_sel=0, delay line cleared, sample_cnt=0.
REQ-027 During and after reset until the first qualifying cycle: fifo_pull=0, pp_acc_valid=0, final_round_en=0, busy=0.
REQ-028 Reset mid-sample SHALL discard the sample with no final_round_en.

Structure
REQ-029 State enum (IDLE, FETCH, MULT) and parameter range limits SHALL live in shared package fir_pkg.
REQ-030 Token delay line and window decode SHALL be sub-module fir_token_delay (parameters MULT_LAT, ACC_STAGES; inputs token_in, flush; outputs pp_acc_valid, final_round_en, any_pending).

Verification (defaults NGROUPS=3, MULT_LAT=2, ACC_STAGES=2)
REQ-031 Single sample: fifo_empty=0 only at cycle 0 -> fifo_pull cycle 0, grp_sel 0,1,2 cycles 2-4, pp_acc_valid cycles 6-7, final_round_en cycle 8, sample_cnt=1 cycle 9, busy=0 cycle 9.
REQ-032 Back-to-back: fifo_empty=0 constant -> fifo_pull cycles 0,4,8,...; final_round_en cycles 8,12,16; no overlapping windows.
REQ-033 Abort: push_coef=1 at cycle 3 -> IDLE cycle 4, grp_sel=0, no pp_acc_valid/final_round_en, sample_cnt unchanged.
REQ-034 Reset at cycle 5 of a sample -> all outputs 0 immediately; no final_round_en afterwards.
REQ-035 Wrap: CNT_W=2, 5 samples -> sample_cnt 1,2,3,0,1.
REQ-036 NGROUPS=5, MULT_LAT=1, ACC_STAGES=5, continuous input -> grp_sel 0..4, fifo_pull every 6 cycles, final_round_en at t+6 for each token t.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and limits for the FIR sequencing controller.
// Holds the multiplier FSM states and legal parameter ranges.
package fir_pkg;

  localparam int NGROUPS_MIN    = 2;
  localparam int NGROUPS_MAX    = 16;
  localparam int MULT_LAT_MIN   = 1;
  localparam int MULT_LAT_MAX   = 8;
  localparam int ACC_STAGES_MIN = 1;
  localparam int CNT_W_MIN      = 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    MULT
  } mstate_e;

  function automatic int gsel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_token_delay.sv
// Sample-token delay line for the FIR controller.
// Decodes accumulate and final-round windows from token age.
module fir_token_delay #(
  parameter int MULT_LAT   = 2,
  parameter int ACC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic token_in,
  input  logic flush,
  output logic pp_acc_valid,
  output logic final_round_en,
  output logic any_pending
);

  localparam int L = MULT_LAT + ACC_STAGES;
  localparam logic [L-1:0] ONES = '1;
  localparam logic [L-1:0] PP_MASK =
    (ONES >> (L - ACC_STAGES)) << (MULT_LAT - 1);

  logic [L-1:0] sr;

  // sr[k] holds the token issued k+1 cycles ago
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sr <= '0;
    else if (flush)
      sr <= '0;
    else
      sr <= {sr[L-2:0], token_in};
  end

  // window decode from token age
  always_comb begin
    pp_acc_valid   = |(sr & PP_MASK);
    final_round_en = sr[L-1];
    any_pending    = |sr;
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: sample fetch, group multiplex,
// and delayed accumulate/round enables with a sample counter.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int NGROUPS    = 3,
  parameter int MULT_LAT   = 2,
  parameter int ACC_STAGES = 2,
  parameter int CNT_W      = 16,
  localparam int GSEL_W    = gsel_w(NGROUPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_coef,
  input  logic              fifo_empty,
  output logic              fifo_pull,
  output logic [GSEL_W-1:0] grp_sel,
  output logic              pp_acc_valid,
  output logic              final_round_en,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_cnt
);

  if (NGROUPS < NGROUPS_MIN || NGROUPS > NGROUPS_MAX) begin : g_bad_ng
    $error("fir_seq_ctrl: NGROUPS out of range");
  end
  if (MULT_LAT < MULT_LAT_MIN || MULT_LAT > MULT_LAT_MAX) begin : g_bad_ml
    $error("fir_seq_ctrl: MULT_LAT out of range");
  end
  if (ACC_STAGES < ACC_STAGES_MIN || ACC_STAGES > NGROUPS) begin : g_bad_as
    $error("fir_seq_ctrl: ACC_STAGES out of range");
  end
  if (CNT_W < CNT_W_MIN) begin : g_bad_cw
    $error("fir_seq_ctrl: CNT_W out of range");
  end

  localparam logic [GSEL_W-1:0] GRP_LAST = GSEL_W'(NGROUPS - 1);

  mstate_e           state, state_d;
  logic [GSEL_W-1:0] grp, grp_d;
  logic              token, flush, pending;

  // FSM state and group counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grp   <= '0;
    end else begin
      state <= state_d;
      grp   <= grp_d;
    end
  end

  // next state, fifo pull and token issue
  always_comb begin
    state_d   = state;
    grp_d     = '0;
    fifo_pull = 1'b0;
    token     = 1'b0;
    flush     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && !push_coef) begin
          fifo_pull = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        flush   = push_coef;
        state_d = push_coef ? IDLE : MULT;
      end
      MULT: begin
        flush = push_coef;
        if (push_coef) begin
          state_d = IDLE;
        end else if (grp == GRP_LAST) begin
          token = 1'b1;
          if (!fifo_empty) begin
            fifo_pull = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          grp_d = grp + GSEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fir_token_delay #(
    .MULT_LAT   (MULT_LAT),
    .ACC_STAGES (ACC_STAGES)
  ) u_delay (
    .clk            (clk),
    .reset          (reset),
    .token_in       (token),
    .flush          (flush),
    .pp_acc_valid   (pp_acc_valid),
    .final_round_en (final_round_en),
    .any_pending    (pending)
  );

  // completed-sample counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sample_cnt <= '0;
    else if (final_round_en)
      sample_cnt <= sample_cnt + CNT_W'(1);
  end

  // status outputs
  always_comb begin
    grp_sel = grp;
    busy    = (state != IDLE) || pending;
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed testbench for fir_seq_ctrl.
// Three instances: defaults, CNT_W=2, and NGROUPS=5/MULT_LAT=1/ACC_STAGES=5.
module tb_fir_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic push_coef = 1'b0;
  logic fifo_empty = 1'b1;

  logic        pull_a, pp_a, fin_a, busy_a;
  logic [1:0]  grp_a;
  logic [15:0] cnt_a;

  logic        pull_w, pp_w, fin_w, busy_w;
  logic [1:0]  grp_w;
  logic [1:0]  cnt_w;

  logic        pull_g, pp_g, fin_g, busy_g;
  logic [2:0]  grp_g;
  logic [15:0] cnt_g;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_seq_ctrl dut_a (
    .clk(clk), .reset(reset), .push_coef(push_coef),
    .fifo_empty(fifo_empty), .fifo_pull(pull_a), .grp_sel(grp_a),
    .pp_acc_valid(pp_a), .final_round_en(fin_a), .busy(busy_a),
    .sample_cnt(cnt_a)
  );

  fir_seq_ctrl #(.CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .push_coef(push_coef),
    .fifo_empty(fifo_empty), .fifo_pull(pull_w), .grp_sel(grp_w),
    .pp_acc_valid(pp_w), .final_round_en(fin_w), .busy(busy_w),
    .sample_cnt(cnt_w)
  );

  fir_seq_ctrl #(.NGROUPS(5), .MULT_LAT(1), .ACC_STAGES(5)) dut_g (
    .clk(clk), .reset(reset), .push_coef(push_coef),
    .fifo_empty(fifo_empty), .fifo_pull(pull_g), .grp_sel(grp_g),
    .pp_acc_valid(pp_g), .final_round_en(fin_g), .busy(busy_g),
    .sample_cnt(cnt_g)
  );

  task automatic do_reset;
    reset = 1'b1;
    push_coef = 1'b0;
    fifo_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] e, o;
    reset = 1'b1;
    @(negedge clk);
    o = {pull_a, grp_a, pp_a, fin_a, busy_a};
    checks++;
    if (o !== 6'd0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got %b cnt %0d exp 000000 cnt 0", o, cnt_a);
    end
    do_reset();
    for (int c = 0; c < 5; c++) begin
      fifo_empty = (c != 0);
      next_cycle();
    end
    reset = 1'b1;
    #1;
    o = {pull_a, grp_a, pp_a, fin_a, busy_a};
    checks++;
    if (o !== 6'd0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset got %b cnt %0d exp 000000 cnt 0", o, cnt_a);
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      e = 6'd0;
      o = {pull_a, grp_a, pp_a, fin_a, busy_a};
      checks++;
      if (o !== e || cnt_a !== 16'd0) begin
        errors++;
        $display("FAIL post_reset c=%0d got %b cnt %0d exp %b cnt 0",
                 c, o, cnt_a, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_single;
    logic [5:0] e, o;
    int g;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      fifo_empty = (c != 0);
      @(negedge clk);
      g = (c >= 2 && c <= 4) ? c - 2 : 0;
      e = {c == 0, 2'(g), c == 6 || c == 7, c == 8, c >= 1 && c <= 8};
      o = {pull_a, grp_a, pp_a, fin_a, busy_a};
      checks++;
      if (o !== e || cnt_a !== ((c >= 9) ? 16'd1 : 16'd0)) begin
        errors++;
        $display("FAIL single c=%0d got %b cnt %0d exp %b",
                 c, o, cnt_a, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] e, o;
    int g, m;
    do_reset();
    for (int c = 0; c < 19; c++) begin
      fifo_empty = (c > 8);
      @(negedge clk);
      m = (c - 2) % 4;
      g = (c >= 2 && c <= 12 && m <= 2) ? m : 0;
      e = {c % 4 == 0 && c <= 8, 2'(g),
           c == 6 || c == 7 || c == 10 || c == 11 || c == 14 || c == 15,
           c == 8 || c == 12 || c == 16, c >= 1 && c <= 16};
      o = {pull_a, grp_a, pp_a, fin_a, busy_a};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b c=%0d got %b exp %b", c, o, e);
      end
      checks++;
      if (pp_a && fin_a) begin
        errors++;
        $display("FAIL b2b_overlap c=%0d got pp=1 fin=1 exp not both", c);
      end
      next_cycle();
    end
    checks++;
    if (cnt_a !== 16'd3) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 3", cnt_a);
    end
  endtask

  task automatic test_abort;
    logic [5:0] e, o;
    int g;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      fifo_empty = (c != 0);
      push_coef = (c == 3);
      @(negedge clk);
      g = (c == 3) ? 1 : 0;
      e = {c == 0, 2'(g), 1'b0, 1'b0, c >= 1 && c <= 3};
      o = {pull_a, grp_a, pp_a, fin_a, busy_a};
      checks++;
      if (o !== e || cnt_a !== 16'd0) begin
        errors++;
        $display("FAIL abort c=%0d got %b cnt %0d exp %b cnt 0",
                 c, o, cnt_a, e);
      end
      next_cycle();
    end
    push_coef = 1'b0;
  endtask

  task automatic test_wrap;
    logic [5:0] e, o;
    int n, g, m;
    do_reset();
    n = 0;
    for (int c = 0; c < 27; c++) begin
      fifo_empty = (c > 16);
      @(negedge clk);
      m = (c - 2) % 4;
      g = (c >= 2 && c <= 20 && m <= 2) ? m : 0;
      e = {c % 4 == 0 && c <= 16, 2'(g),
           c >= 6 && c <= 23 && (c % 4 == 2 || c % 4 == 3),
           c >= 8 && c <= 24 && c % 4 == 0, c >= 1 && c <= 24};
      o = {pull_w, grp_w, pp_w, fin_w, busy_w};
      checks++;
      if (o !== e || cnt_w !== 2'(n % 4) || cnt_a !== 16'(n)) begin
        errors++;
        $display("FAIL wrap c=%0d got %b cnt_w %0d cnt %0d exp %b %0d %0d",
                 c, o, cnt_w, cnt_a, e, n % 4, n);
      end
      if (c >= 8 && c <= 24 && c % 4 == 0) n++;
      next_cycle();
    end
  endtask

  task automatic test_groups5;
    logic [7:0] e, o;
    int n, g, m;
    logic pp;
    do_reset();
    n = 0;
    for (int c = 0; c < 27; c++) begin
      fifo_empty = (c > 12);
      @(negedge clk);
      m = (c - 2) % 6;
      g = (c >= 2 && c <= 18 && m <= 4) ? m : 0;
      pp = (c >= 7 && c <= 11) || (c >= 13 && c <= 17) ||
           (c >= 19 && c <= 23);
      e = {c % 6 == 0 && c <= 12, 3'(g), pp,
           c == 12 || c == 18 || c == 24, c >= 1 && c <= 24, 1'b0};
      o = {pull_g, grp_g, pp_g, fin_g, busy_g, 1'b0};
      checks++;
      if (o !== e || cnt_g !== 16'(n)) begin
        errors++;
        $display("FAIL groups5 c=%0d got %b cnt %0d exp %b cnt %0d",
                 c, o, cnt_g, e, n);
      end
      if (c == 12 || c == 18 || c == 24) n++;
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_wrap();
    test_groups5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
